// File: rtl/beat_tracker.sv
// Beat tracker: edge-detects the beat level, applies a refractory lockout, measures
// the interval between accepted beats and converts it to BPM with a restoring divider.
module beat_tracker #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int LOCKOUT_CYCLES = 15_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int INTERVAL_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      beat_pulse,
    output logic                      beat_event,
    output logic [INTERVAL_WIDTH-1:0] beat_interval,
    output logic                      interval_valid,
    output logic [7:0]                bpm,
    output logic                      bpm_valid
);
    localparam int W         = INTERVAL_WIDTH;
    localparam int LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
    localparam int DIV_CNT_W = $clog2(W + 1);

    localparam logic [W-1:0]         K_CONST     = W'(64'(60) * 64'(CLK_FREQ_HZ));
    localparam logic [W-1:0]         TIMEOUT_VAL = W'(TIMEOUT_CYCLES);
    localparam logic [LOCK_W-1:0]    LOCK_VAL    = LOCK_W'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        TRACK
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              r_bp_q;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic [W-1:0]      r_int_cnt;

    logic w_edge;
    logic w_timeout;
    logic w_accept;
    logic w_latch;

    // The dividend register shifts out MSB-first while quotient bits shift in at the LSB.
    logic [W-1:0]         r_div_q;
    logic [W-1:0]         r_div_rem;
    logic [W-1:0]         r_div_den;
    logic [DIV_CNT_W-1:0] r_div_cnt;
    logic                 r_div_busy;
    logic                 r_bpm_load;
    logic [7:0]           r_bpm_sat;

    logic [W:0]   w_shift;
    logic         w_ge;
    logic [W-1:0] w_sub;

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_edge       = beat_pulse & ~r_bp_q;
        w_timeout    = (r_state != IDLE) && (r_int_cnt == TIMEOUT_VAL);
        w_accept     = w_edge && (r_lock_cnt == '0) && !w_timeout;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = FIRST;
                end
            end
            FIRST, TRACK: begin
                if (w_timeout) begin
                    w_state_next = IDLE;
                end else if (w_accept) begin
                    w_state_next = TRACK;
                    w_latch      = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bp_q         <= 1'b0;
            r_lock_cnt     <= '0;
            r_int_cnt      <= '0;
            beat_event     <= 1'b0;
            interval_valid <= 1'b0;
            beat_interval  <= '0;
        end else begin
            r_bp_q         <= beat_pulse;
            beat_event     <= w_accept;
            interval_valid <= w_latch;

            if (w_accept) begin
                r_lock_cnt <= LOCK_VAL;
            end else if (r_lock_cnt != '0) begin
                r_lock_cnt <= r_lock_cnt - LOCK_W'(1);
            end

            // The count is cycles since the last accepted beat, so the interval is count+1.
            if (w_timeout || w_accept) begin
                r_int_cnt <= '0;
            end else if ((r_state != IDLE) && (r_int_cnt != TIMEOUT_VAL)) begin
                r_int_cnt <= r_int_cnt + W'(1);
            end

            if (w_latch) begin
                beat_interval <= r_int_cnt + W'(1);
            end
        end
    end

    always_comb begin
        w_shift = {r_div_rem, r_div_q[W-1]};
        w_ge    = (w_shift >= {1'b0, r_div_den});
        w_sub   = w_shift[W-1:0] - r_div_den;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q    <= '0;
            r_div_rem  <= '0;
            r_div_den  <= '0;
            r_div_cnt  <= '0;
            r_div_busy <= 1'b0;
            r_bpm_load <= 1'b0;
            r_bpm_sat  <= '0;
            bpm        <= '0;
            bpm_valid  <= 1'b0;
        end else begin
            r_bpm_load <= 1'b0;
            if (w_latch) begin
                r_div_q    <= K_CONST;
                r_div_rem  <= '0;
                r_div_den  <= r_int_cnt + W'(1);
                r_div_cnt  <= DIV_CNT_W'(W);
                r_div_busy <= 1'b1;
            end else if (r_div_busy) begin
                if (r_div_cnt != '0) begin
                    r_div_rem <= w_ge ? w_sub : w_shift[W-1:0];
                    r_div_q   <= {r_div_q[W-2:0], w_ge};
                    r_div_cnt <= r_div_cnt - DIV_CNT_W'(1);
                end else begin
                    // Saturate in a separate stage so bpm only ever sees a finished result.
                    r_bpm_sat  <= (|r_div_q[W-1:8]) ? 8'hFF : r_div_q[7:0];
                    r_div_busy <= 1'b0;
                    r_bpm_load <= 1'b1;
                end
            end

            if (w_timeout) begin
                bpm       <= '0;
                bpm_valid <= 1'b0;
            end else if (r_bpm_load) begin
                bpm       <= r_bpm_sat;
                bpm_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_beat_tracker.sv
// Self-checking bench for beat_tracker: randomized pulse trains compared cycle by cycle
// against a time-based reference model (beat times, lockout and timeout windows, K/interval).
module tb_beat_tracker;
    localparam int CLK_HZ = 1000;
    localparam int LOCK   = 100;
    localparam int TMO    = 2000;
    localparam int W      = 32;
    localparam int K      = 60 * CLK_HZ;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         beat_pulse = 1'b0;
    logic         beat_event;
    logic [W-1:0] beat_interval;
    logic         interval_valid;
    logic [7:0]   bpm;
    logic         bpm_valid;

    beat_tracker #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .LOCKOUT_CYCLES(LOCK),
        .TIMEOUT_CYCLES(TMO),
        .INTERVAL_WIDTH(W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .beat_pulse    (beat_pulse),
        .beat_event    (beat_event),
        .beat_interval (beat_interval),
        .interval_valid(interval_valid),
        .bpm           (bpm),
        .bpm_valid     (bpm_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: times are cycle indices counted from reset release.
    int           t;
    int           ref_t;
    bit           ref_ok;
    int           acc_t;
    bit           acc_ok;
    bit           p_last;
    int           pend_t;
    bit           pend_ok;
    int           pend_v;
    logic         exp_event;
    logic         exp_iv;
    logic [W-1:0] exp_int;
    logic [7:0]   exp_bpm;
    logic         exp_bv;

    function automatic int expected_bpm(input int interval);
        int q;
        q = K / interval;
        return (q > 255) ? 255 : q;
    endfunction

    function automatic string fields(input logic ev, input logic iv, input logic [W-1:0] iv_val,
                                     input logic [7:0] b, input logic bv);
        return $sformatf("ev=%0b iv=%0b interval=%0d bpm=%0d bv=%0b", ev, iv, iv_val, b, bv);
    endfunction

    task automatic model_reset();
        t = 0; ref_ok = 0; acc_ok = 0; p_last = 0; pend_ok = 0;
        ref_t = 0; acc_t = 0; pend_t = 0; pend_v = 0;
        exp_event = 0; exp_iv = 0; exp_int = '0; exp_bpm = '0; exp_bv = 0;
    endtask

    // Drive one cycle of beat_pulse, sample #1 after the edge, advance the model.
    task automatic tick(input logic p);
        bit edge_seen;
        bit timed_out;
        beat_pulse = p;
        @(posedge clk);
        #1;
        t++;
        edge_seen = p && !p_last;
        p_last    = p;
        timed_out = 0;
        exp_event = 0;
        exp_iv    = 0;
        if (pend_ok && t == pend_t) begin
            exp_bpm = 8'(pend_v);
            exp_bv  = 1;
            pend_ok = 0;
        end
        if (ref_ok && (t - ref_t) > TMO) begin
            ref_ok    = 0;
            timed_out = 1;
            exp_bpm   = 0;
            exp_bv    = 0;
        end
        if (edge_seen && !timed_out && (!acc_ok || (t - acc_t) > LOCK)) begin
            exp_event = 1;
            if (ref_ok) begin
                exp_iv  = 1;
                exp_int = W'(t - ref_t);
                pend_ok = 1;
                pend_t  = t + W + 2;
                pend_v  = expected_bpm(t - ref_t);
            end
            ref_ok = 1; ref_t = t;
            acc_ok = 1; acc_t = t;
        end
        if (beat_event)
            $display("[TB] t=%0d beat_event interval_valid=%0b interval=%0d bpm=%0d",
                     t, interval_valid, beat_interval, bpm);
    endtask

    task automatic do_reset();
        beat_pulse = 0;
        @(negedge clk);
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 0;
        beat_pulse = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({beat_event, interval_valid, beat_interval, bpm, bpm_valid} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %s, expected all zero",
                     fields(beat_event, interval_valid, beat_interval, bpm, bpm_valid));
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int c = 0; c < 30; c++) begin
            tick(c == 5);
            n_tests++;
            if ({beat_event, interval_valid, beat_interval, bpm, bpm_valid} !==
                {exp_event, exp_iv, exp_int, exp_bpm, exp_bv}) begin
                n_fail++;
                $display("FAIL reset_first_beat t=%0d: got %s, expected %s", t,
                         fields(beat_event, interval_valid, beat_interval, bpm, bpm_valid),
                         fields(exp_event, exp_iv, exp_int, exp_bpm, exp_bv));
                return;
            end
        end
    endtask

    task automatic test_periodic(input int period, input int beats, input int want_bpm);
        int  start;
        int  width;
        int  total;
        logic p;
        do_reset();
        start = $urandom_range(5, 40);
        width = $urandom_range(1, 30);
        total = start + period * beats + 60;
        for (int c = 0; c < total; c++) begin
            p = 0;
            for (int b = 0; b < beats; b++)
                if (c >= start + b * period && c < start + b * period + width) p = 1;
            tick(p);
            n_tests++;
            if ({beat_event, interval_valid, beat_interval, bpm, bpm_valid} !==
                {exp_event, exp_iv, exp_int, exp_bpm, exp_bv}) begin
                n_fail++;
                $display("FAIL periodic_%0d t=%0d: got %s, expected %s", period, t,
                         fields(beat_event, interval_valid, beat_interval, bpm, bpm_valid),
                         fields(exp_event, exp_iv, exp_int, exp_bpm, exp_bv));
                return;
            end
        end
        n_tests++;
        if (bpm !== 8'(want_bpm) || bpm_valid !== 1'b1 || beat_interval !== W'(period)) begin
            n_fail++;
            $display("FAIL periodic_%0d_final: got bpm=%0d bv=%0b interval=%0d, expected bpm=%0d bv=1 interval=%0d",
                     period, bpm, bpm_valid, beat_interval, want_bpm, period);
        end
    endtask

    task automatic test_lockout();
        int   start;
        int   events;
        logic p;
        do_reset();
        start  = $urandom_range(5, 40);
        events = 0;
        for (int c = 0; c < start + 220; c++) begin
            p = (c == start) || (c == start + 50) || (c == start + 99) || (c == start + 150);
            tick(p);
            if (beat_event === 1'b1) events++;
            n_tests++;
            if ({beat_event, interval_valid, beat_interval, bpm, bpm_valid} !==
                {exp_event, exp_iv, exp_int, exp_bpm, exp_bv}) begin
                n_fail++;
                $display("FAIL lockout t=%0d: got %s, expected %s", t,
                         fields(beat_event, interval_valid, beat_interval, bpm, bpm_valid),
                         fields(exp_event, exp_iv, exp_int, exp_bpm, exp_bv));
                return;
            end
        end
        n_tests++;
        if (events != 2 || beat_interval !== W'(150) || bpm !== 8'd255) begin
            n_fail++;
            $display("FAIL lockout_final: got events=%0d interval=%0d bpm=%0d, expected events=2 interval=150 bpm=255",
                     events, beat_interval, bpm);
        end
    endtask

    task automatic test_held_high();
        int   start;
        int   events_high;
        logic p;
        do_reset();
        start       = $urandom_range(5, 40);
        events_high = 0;
        for (int c = 0; c < start + 700; c++) begin
            p = (c >= start && c < start + 300) || (c >= start + 600 && c < start + 605);
            tick(p);
            if (beat_event === 1'b1 && c < start + 320) events_high++;
            n_tests++;
            if ({beat_event, interval_valid, beat_interval, bpm, bpm_valid} !==
                {exp_event, exp_iv, exp_int, exp_bpm, exp_bv}) begin
                n_fail++;
                $display("FAIL held_high t=%0d: got %s, expected %s", t,
                         fields(beat_event, interval_valid, beat_interval, bpm, bpm_valid),
                         fields(exp_event, exp_iv, exp_int, exp_bpm, exp_bv));
                return;
            end
        end
        n_tests++;
        if (events_high != 1 || beat_interval !== W'(600) || bpm !== 8'd100) begin
            n_fail++;
            $display("FAIL held_high_final: got events=%0d interval=%0d bpm=%0d, expected events=1 interval=600 bpm=100",
                     events_high, beat_interval, bpm);
        end
    endtask

    task automatic test_timeout();
        int   start;
        int   width;
        int   n_ev;
        int   ev2_t;
        int   fall_t;
        logic prev_bv;
        logic third_iv;
        logic p;
        do_reset();
        start    = $urandom_range(5, 40);
        width    = $urandom_range(1, 20);
        n_ev     = 0;
        ev2_t    = -1;
        fall_t   = -1;
        prev_bv  = 0;
        third_iv = 1'bx;
        for (int c = 0; c < start + 500 + TMO + 120; c++) begin
            p = (c >= start && c < start + width) ||
                (c >= start + 500 && c < start + 500 + width) ||
                (c >= start + 550 + TMO && c < start + 550 + TMO + width);
            tick(p);
            if (beat_event === 1'b1) begin
                n_ev++;
                if (n_ev == 2) ev2_t = t;
                if (n_ev == 3) third_iv = interval_valid;
            end
            if (prev_bv === 1'b1 && bpm_valid === 1'b0 && fall_t < 0) fall_t = t;
            prev_bv = bpm_valid;
            n_tests++;
            if ({beat_event, interval_valid, beat_interval, bpm, bpm_valid} !==
                {exp_event, exp_iv, exp_int, exp_bpm, exp_bv}) begin
                n_fail++;
                $display("FAIL timeout t=%0d: got %s, expected %s", t,
                         fields(beat_event, interval_valid, beat_interval, bpm, bpm_valid),
                         fields(exp_event, exp_iv, exp_int, exp_bpm, exp_bv));
                return;
            end
        end
        n_tests++;
        if (n_ev != 3 || fall_t - ev2_t != TMO + 1 || third_iv !== 1'b0 || bpm !== 8'd0) begin
            n_fail++;
            $display("FAIL timeout_final: got events=%0d drop_delay=%0d third_iv=%0b bpm=%0d, expected events=3 drop_delay=%0d third_iv=0 bpm=0",
                     n_ev, fall_t - ev2_t, third_iv, bpm, TMO + 1);
        end
    endtask

    task automatic test_reset_mid_division();
        int   start;
        int   n_ev;
        int   after;
        logic p;
        do_reset();
        start = $urandom_range(5, 40);
        n_ev  = 0;
        after = -1;
        for (int c = 0; c < start + 1100 && after != 10; c++) begin
            p = (c == start) || (c == start + 500) || (c == start + 1000);
            tick(p);
            if (after >= 0) after++;
            if (beat_event === 1'b1) begin
                n_ev++;
                if (n_ev == 3) after = 0;
            end
            n_tests++;
            if ({beat_event, interval_valid, beat_interval, bpm, bpm_valid} !==
                {exp_event, exp_iv, exp_int, exp_bpm, exp_bv}) begin
                n_fail++;
                $display("FAIL reset_mid_pre t=%0d: got %s, expected %s", t,
                         fields(beat_event, interval_valid, beat_interval, bpm, bpm_valid),
                         fields(exp_event, exp_iv, exp_int, exp_bpm, exp_bv));
                return;
            end
        end
        n_tests++;
        if (bpm !== 8'd120 || bpm_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_before: got bpm=%0d bv=%0b, expected bpm=120 bv=1", bpm, bpm_valid);
        end
        #2;
        rst_n = 0;
        #1;
        n_tests++;
        if ({beat_event, interval_valid, beat_interval, bpm, bpm_valid} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %s, expected all zero",
                     fields(beat_event, interval_valid, beat_interval, bpm, bpm_valid));
        end
        beat_pulse = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int c = 0; c < 420; c++) begin
            tick((c >= 20 && c < 23) || (c >= 320 && c < 323));
            n_tests++;
            if ({beat_event, interval_valid, beat_interval, bpm, bpm_valid} !==
                {exp_event, exp_iv, exp_int, exp_bpm, exp_bv}) begin
                n_fail++;
                $display("FAIL reset_mid_post t=%0d: got %s, expected %s", t,
                         fields(beat_event, interval_valid, beat_interval, bpm, bpm_valid),
                         fields(exp_event, exp_iv, exp_int, exp_bpm, exp_bv));
                return;
            end
        end
        n_tests++;
        if (bpm !== 8'd200 || bpm_valid !== 1'b1 || beat_interval !== W'(300)) begin
            n_fail++;
            $display("FAIL reset_mid_final: got bpm=%0d bv=%0b interval=%0d, expected bpm=200 bv=1 interval=300",
                     bpm, bpm_valid, beat_interval);
        end
    endtask

    task automatic test_random();
        logic lv[$];
        int   sel;
        int   gap;
        int   hi;
        do_reset();
        while (lv.size() < 9000) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      gap = $urandom_range(1, 90);
            else if (sel < 8) gap = $urandom_range(91, 700);
            else              gap = $urandom_range(1900, 2100);
            hi = $urandom_range(1, 40);
            repeat (gap) lv.push_back(1'b0);
            repeat (hi) lv.push_back(1'b1);
        end
        foreach (lv[i]) begin
            tick(lv[i]);
            n_tests++;
            if ({beat_event, interval_valid, beat_interval, bpm, bpm_valid} !==
                {exp_event, exp_iv, exp_int, exp_bpm, exp_bv}) begin
                n_fail++;
                $display("FAIL random t=%0d: got %s, expected %s", t,
                         fields(beat_event, interval_valid, beat_interval, bpm, bpm_valid),
                         fields(exp_event, exp_iv, exp_int, exp_bpm, exp_bv));
                return;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_periodic(500, 5, 120);
        test_periodic(250, 5, 240);
        test_periodic(200, 5, 255);
        test_lockout();
        test_held_high();
        test_timeout();
        test_reset_mid_division();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/beat_tracker.md
# beat_tracker

Consumes the single-bit `beat_pulse` level from the SNR threshold detector and turns it into clean beat events plus a tempo estimate. It edge-detects the level, applies a refractory lockout, and measures the clock-cycle interval between accepted beats. It converts that interval to beats-per-minute with a sequential divider. Its outputs feed the display and LED logic.

## Interface

- `CLK_FREQ_HZ`, 50_000_000, clock frequency; sets the BPM constant K = 60*CLK_FREQ_HZ.
- `LOCKOUT_CYCLES`, 15_000_000, refractory period after an accepted beat; must be >= 2*INTERVAL_WIDTH.
- `TIMEOUT_CYCLES`, 100_000_000, idle limit before tracking is dropped; must be > LOCKOUT_CYCLES.
- `INTERVAL_WIDTH`, 32, width of the interval counter and of the divider; K < 2^INTERVAL_WIDTH is required.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `beat_pulse`  in  1  level from the threshold detector, synchronous to `clk`.
- `beat_event`  out  1  one-cycle strobe per accepted beat.
- `beat_interval`  out  INTERVAL_WIDTH  cycles between the last two accepted beats.
- `interval_valid`  out  1  one-cycle strobe; `beat_interval` was just updated.
- `bpm`  out  8  tempo estimate, saturating at 255.
- `bpm_valid`  out  1  level; `bpm` holds a live estimate.

## Operation

- `beat_pulse` is registered once as `bp_q`. A rising edge is `beat_pulse & ~bp_q`. A level held high yields exactly one edge.
- An edge is accepted only when the lockout counter is zero. Accepting an edge loads the lockout counter with LOCKOUT_CYCLES. The counter decrements to 0 each cycle, and edges seen while it is nonzero are discarded.
- The state machine has three states:
  - IDLE: no reference beat. An accepted edge moves to FIRST and clears the interval counter.
  - FIRST: one beat seen, counting. An accepted edge latches the interval, starts the divider and moves to TRACK.
  - TRACK: each accepted edge latches the interval, restarts the interval counter and starts the divider.
- The interval counter runs in FIRST and TRACK and saturates at TIMEOUT_CYCLES. Reaching TIMEOUT_CYCLES forces IDLE, clears `bpm` to 0 and deasserts `bpm_valid`. The timeout takes precedence over a same-cycle edge, and that edge is ignored.
- `beat_interval` = (cycle of current `beat_event`) - (cycle of previous `beat_event`).
- The divider is a restoring divider that computes K / interval, one quotient bit per cycle, INTERVAL_WIDTH iterations.
  - A quotient above 255 loads 255. Otherwise `bpm` loads quotient[7:0].
  - `bpm_valid` rises on the first completed division after IDLE.
- The divider is never restarted while busy, and the lockout constraint guarantees this.

## Timing

- Reset values: `beat_event`=0, `beat_interval`=0, `interval_valid`=0, `bpm`=0, `bpm_valid`=0. The state is IDLE and all counters are 0.
- Reset asserted mid-division aborts the division. No partial `bpm` is ever visible.
- `beat_event` is asserted in the cycle after the first rising `clk` edge at which `beat_pulse`=1 is sampled, i.e. one cycle of latency.
- `interval_valid` and the `beat_interval` update occur in the same cycle as `beat_event`, from the second accepted beat onward.
- `bpm` and `bpm_valid` update exactly INTERVAL_WIDTH+2 cycles after the `beat_event` that started the division. Between updates `bpm` holds its previous value.
- Lockout window: edges are blocked for LOCKOUT_CYCLES cycles starting the cycle after `beat_event`.
- The timeout fires TIMEOUT_CYCLES cycles after the last `beat_event`. `bpm`=0 and `bpm_valid`=0 take effect on the following cycle.

## Test plan

All scenarios use CLK_FREQ_HZ=1000 (K=60000), LOCKOUT_CYCLES=100, TIMEOUT_CYCLES=2000, INTERVAL_WIDTH=32.

- Pulses every 500 cycles, 5 beats -> `beat_interval`=500 from the 2nd beat onward; `bpm`=120 and `bpm_valid`=1 at 34 cycles after the 2nd `beat_event`.
- Pulses every 250 cycles -> `bpm`=240. Pulses every 200 cycles -> quotient 300, so `bpm`=255 (saturated).
- Lockout: beat at t0, then extra pulses at t0+50 and t0+99 -> no `beat_event`. A pulse at t0+150 -> accepted, `beat_interval`=150, `bpm`=400 saturated to 255.
- `beat_pulse` held high for 300 cycles -> exactly one `beat_event`. Interval measured to the next rising edge only.
- Two beats 500 apart, then silence -> `bpm`=120; exactly 2000 cycles after the last beat, `bpm_valid`=0 and `bpm`=0. The next beat gives IDLE -> FIRST, with no `interval_valid`.
- `rst_n` pulsed low 10 cycles after a TRACK beat (divider busy) -> all outputs read 0 immediately. After release, the first pulse is treated as an IDLE beat.
